// File: rtl/cpu_traffic_gen.sv
// cpu_traffic_gen: table-driven request sequencer.
// A small table of read/write requests is loaded while idle, then replayed in
// order on start. Each request is held until hit; read returns are compared
// against the stored expected data. A request that waits too long aborts the run.
//
// Ports
//   clock, reset          rising-edge clock, async active-low reset
//   cfg_we/idx/rw/addr/data  table write port (only honoured in IDLE)
//   cfg_len               number of entries to run, sampled at start
//   start                 begin a sequence
//   hit, rData            current request completed / read return data
//   Address, Write_Data   current request (zero outside RUN)
//   read, write           request strobes
//   busy, finish          running / completed-or-aborted flags
//   mismatch_cnt          saturating read-data mismatch count
//   timeout               sticky: a request exceeded TO_CYC cycles
//
// state | meaning
// IDLE  | table writable, waiting for start
// RUN   | presenting entry[ptr], waiting for hit
// DONE  | all entries completed (or invalid length), waits for start low
// ABORT | a request timed out, waits for start low

module cpu_traffic_gen #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int TO_CYC = 15
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)-1:0]   cfg_idx,
  input  logic                       cfg_rw,
  input  logic [ADDR_W-1:0]          cfg_addr,
  input  logic [DATA_W-1:0]          cfg_data,
  input  logic [$clog2(DEPTH):0]     cfg_len,
  input  logic                       start,
  input  logic                       hit,
  input  logic [DATA_W-1:0]          rData,
  output logic [ADDR_W-1:0]          Address,
  output logic [DATA_W-1:0]          Write_Data,
  output logic                       read,
  output logic                       write,
  output logic                       busy,
  output logic                       finish,
  output logic [7:0]                 mismatch_cnt,
  output logic                       timeout
);

  localparam int IDX_W  = $clog2(DEPTH);
  localparam int LEN_W  = IDX_W + 1;
  localparam int WAIT_W = $clog2(TO_CYC + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE, ABORT} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [7:0]          mm_q, mm_d;
  logic                to_q, to_d;

  // Request table; deliberately not reset so a reset mid-run keeps the program.
  logic                tbl_rw   [DEPTH];
  logic [ADDR_W-1:0]   tbl_addr [DEPTH];
  logic [DATA_W-1:0]   tbl_data [DEPTH];

  logic                len_ok;
  logic                last_entry;
  logic                rd_miss;

  always_ff @(posedge clock) begin
    if (state_q == IDLE && cfg_we) begin
      tbl_rw[cfg_idx]   <= cfg_rw;
      tbl_addr[cfg_idx] <= cfg_addr;
      tbl_data[cfg_idx] <= cfg_data;
    end
  end

  assign len_ok     = (cfg_len != '0) && (cfg_len <= LEN_W'(DEPTH));
  assign last_entry = (LEN_W'(ptr_q) == len_q - LEN_W'(1));
  assign rd_miss    = tbl_rw[ptr_q] && (rData != tbl_data[ptr_q]);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      len_q   <= '0;
      wait_q  <= '0;
      mm_q    <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      wait_q  <= wait_d;
      mm_q    <= mm_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    wait_d  = wait_q;
    mm_d    = mm_q;
    to_d    = to_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d = RUN;
            ptr_d   = '0;
            len_d   = cfg_len;
            wait_d  = '0;
            mm_d    = '0;
            to_d    = 1'b0;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        // A hit always wins over the timeout threshold on the same edge.
        if (hit) begin
          ptr_d  = ptr_q + IDX_W'(1);
          wait_d = '0;
          if (rd_miss && mm_q != 8'hFF) mm_d = mm_q + 8'd1;
          if (last_entry) state_d = DONE;
        end else if (wait_q == WAIT_W'(TO_CYC - 1)) begin
          to_d    = 1'b1;
          state_d = ABORT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      DONE, ABORT: begin
        // Leaving only on start low means a held start cannot retrigger.
        if (!start) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Write_Data mirrors the entry data field for both kinds of request.
  assign busy         = (state_q == RUN);
  assign finish       = (state_q == DONE) || (state_q == ABORT);
  assign read         = busy &&  tbl_rw[ptr_q];
  assign write        = busy && !tbl_rw[ptr_q];
  assign Address      = busy ? tbl_addr[ptr_q] : '0;
  assign Write_Data   = busy ? tbl_data[ptr_q] : '0;
  assign mismatch_cnt = mm_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_cpu_traffic_gen.sv
module tb_cpu_traffic_gen;

  localparam int DEPTH  = 512;
  localparam int TO_CYC = 15;
  localparam int M_IDLE = 0, M_RUN = 1, M_DONE = 2, M_ABORT = 3;

  logic        clock = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [8:0]  cfg_idx;
  logic        cfg_rw;
  logic [7:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [9:0]  cfg_len;
  logic        start;
  logic        hit;
  logic [31:0] rData;
  logic [7:0]  Address;
  logic [31:0] Write_Data;
  logic        read, write, busy, finish, timeout;
  logic [7:0]  mismatch_cnt;

  cpu_traffic_gen #(.ADDR_W(8), .DATA_W(32), .DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .clock(clock), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_rw(cfg_rw),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_len(cfg_len), .start(start),
    .hit(hit), .rData(rData), .Address(Address), .Write_Data(Write_Data),
    .read(read), .write(write), .busy(busy), .finish(finish),
    .mismatch_cnt(mismatch_cnt), .timeout(timeout)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_mis = 0;

  // reference model: request list replayed in order, each held until hit
  logic        m_rw   [DEPTH];
  logic [7:0]  m_addr [DEPTH];
  logic [31:0] m_data [DEPTH];
  int m_state, m_idx, m_len, m_wait, m_mm, m_to;

  typedef struct {
    logic        start;
    logic        hit;
    logic [31:0] rdata;
    logic        busy;
    logic        finish;
    logic        rd;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [7:0]  mm;
    logic        to;
  } vec_t;
  vec_t vt[12];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [52:0] dut_bundle();
    return {busy, finish, read, write, Address, Write_Data, mismatch_cnt, timeout};
  endfunction

  task automatic model_reset();
    m_state = M_IDLE; m_idx = 0; m_len = 0; m_wait = 0; m_mm = 0; m_to = 0;
  endtask

  task automatic model_step();
    case (m_state)
      M_IDLE: begin
        if (cfg_we) begin
          m_rw[cfg_idx] = cfg_rw; m_addr[cfg_idx] = cfg_addr; m_data[cfg_idx] = cfg_data;
        end
        if (start) begin
          if (int'(cfg_len) >= 1 && int'(cfg_len) <= DEPTH) begin
            m_state = M_RUN; m_idx = 0; m_len = int'(cfg_len);
            m_wait = 0; m_mm = 0; m_to = 0;
          end else m_state = M_DONE;
        end
      end
      M_RUN: begin
        if (hit) begin
          if (m_rw[m_idx] && rData != m_data[m_idx] && m_mm < 255) m_mm++;
          m_idx++;
          m_wait = 0;
          if (m_idx == m_len) m_state = M_DONE;
        end else begin
          m_wait++;
          if (m_wait == TO_CYC) begin m_to = 1; m_state = M_ABORT; end
        end
      end
      default: if (!start) m_state = M_IDLE;
    endcase
  endtask

  task automatic check_model();
    logic run;
    logic [52:0] e;
    run = (m_state == M_RUN);
    e = {run, (m_state == M_DONE || m_state == M_ABORT),
         run && m_rw[m_idx], run && !m_rw[m_idx],
         run ? m_addr[m_idx] : 8'h00, run ? m_data[m_idx] : 32'h0,
         8'(m_mm), (m_to != 0)};
    chk("model", 64'(dut_bundle()), 64'(e));
  endtask

  task automatic tick(input logic st, input logic h, input logic [31:0] rd);
    start = st; hit = h; rData = rd;
    @(posedge clock);
    model_step();
    #1;
    check_model();
    cfg_we = 1'b0;
  endtask

  task automatic load(input int idx, input logic rw, input logic [7:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = 9'(idx); cfg_rw = rw; cfg_addr = a; cfg_data = d;
    tick(1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'h68, 32'd841, 8'd0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 32'd841, 1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 32'd676, 8'd0, 1'b0};
    vt[2]  = '{1'b0, 1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 32'd179, 8'd0, 1'b0};
    vt[3]  = '{1'b0, 1'b1, 32'd179, 1'b1, 1'b0, 1'b0, 1'b1, 8'hD4, 32'd280, 8'd0, 1'b0};
    vt[4]  = '{1'b0, 1'b1, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0,   8'd0, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,   8'd0, 1'b0};
    vt[6]  = '{1'b1, 1'b0, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'h68, 32'd841, 8'd0, 1'b0};
    vt[7]  = '{1'b0, 1'b1, 32'd0,   1'b1, 1'b0, 1'b0, 1'b1, 8'h34, 32'd676, 8'd1, 1'b0};
    vt[8]  = '{1'b0, 1'b1, 32'd0,   1'b1, 1'b0, 1'b1, 1'b0, 8'h30, 32'd179, 8'd1, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 32'd0,   1'b1, 1'b0, 1'b0, 1'b1, 8'hD4, 32'd280, 8'd2, 1'b0};
    vt[10] = '{1'b0, 1'b1, 32'd0,   1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 32'd0,   8'd2, 1'b0};
    vt[11] = '{1'b0, 1'b0, 32'd0,   1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'd0,   8'd2, 1'b0};

    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_rw = 1'b0; cfg_addr = '0;
    cfg_data = '0; cfg_len = '0; start = 1'b0; hit = 1'b0; rData = '0;
    model_reset();
    #12;
    chk("reset_state", 64'(dut_bundle()), 64'h0);
    #5 reset = 1'b1;

    for (int i = 0; i < DEPTH; i++) load(i, 1'(i), 8'(i) ^ 8'h5A, 32'(i * 3 + 7));
    load(0, 1'b1, 8'h68, 32'd841);
    load(1, 1'b0, 8'h34, 32'd676);
    load(2, 1'b1, 8'h30, 32'd179);
    load(3, 1'b0, 8'hD4, 32'd280);

    // four-entry program: correct read data, then wrong read data
    cfg_len = 10'd4;
    for (int v = 0; v < 12; v++) begin
      tick(vt[v].start, vt[v].hit, vt[v].rdata);
      chk($sformatf("vec%0d", v), 64'(dut_bundle()),
          64'({vt[v].busy, vt[v].finish, vt[v].rd, vt[v].wr, vt[v].addr,
               vt[v].wdata, vt[v].mm, vt[v].to}));
    end

    // timeout with hit withheld
    cfg_len = 10'd2;
    tick(1'b1, 1'b0, 32'h0);
    for (int c = 0; c < TO_CYC - 1; c++) tick(1'b0, 1'b0, 32'h0);
    chk("to_pre_busy", 64'({busy, timeout}), 64'b10);
    tick(1'b0, 1'b0, 32'h0);
    chk("to_abort", 64'({busy, finish, timeout}), 64'b011);
    tick(1'b0, 1'b0, 32'h0);
    chk("to_hold_idle", 64'({finish, timeout}), 64'b01);

    // hit exactly on the threshold edge completes instead of timing out
    tick(1'b1, 1'b0, 32'h0);
    chk("to_cleared", 64'(timeout), 64'h0);
    for (int c = 0; c < TO_CYC - 1; c++) tick(1'b0, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'd841);
    chk("thr_hit", 64'({busy, timeout, Address}), 64'({2'b10, 8'h34}));
    tick(1'b0, 1'b1, 32'h0);
    chk("thr_done", 64'({finish, timeout}), 64'b10);
    tick(1'b0, 1'b0, 32'h0);

    // asynchronous reset mid-run at ptr=2, then replay
    cfg_len = 10'd4;
    tick(1'b1, 1'b0, 32'h0);
    tick(1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b1, 32'h0);
    chk("pre_reset", 64'({busy, Address, mismatch_cnt}), 64'({1'b1, 8'h30, 8'd1}));
    #2 reset = 1'b0;
    #1;
    chk("async_reset", 64'(dut_bundle()), 64'h0);
    model_reset();
    @(posedge clock);
    #3 reset = 1'b1;
    tick(1'b1, 1'b0, 32'h0);
    chk("replay_first", 64'({read, Address, Write_Data}), 64'({1'b1, 8'h68, 32'd841}));
    tick(1'b0, 1'b1, 32'd841);
    tick(1'b0, 1'b1, 32'h0);
    tick(1'b0, 1'b1, 32'd179);
    tick(1'b1, 1'b1, 32'h0);
    chk("replay_done", 64'({finish, mismatch_cnt}), 64'({1'b1, 8'd0}));
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b1, 32'h0);
    chk("held_no_retrig", 64'({busy, finish}), 64'b01);
    tick(1'b0, 1'b0, 32'h0);

    // invalid lengths finish without requests, even with start held
    for (int k = 0; k < 2; k++) begin
      logic seen_rw;
      seen_rw = 1'b0;
      cfg_len = (k == 0) ? 10'd0 : 10'(DEPTH + 1);
      for (int c = 0; c < 5; c++) begin
        tick(1'b1, 1'b1, 32'h0);
        seen_rw = seen_rw | read | write | busy;
      end
      chk($sformatf("badlen%0d", k), 64'({seen_rw, finish}), 64'b01);
      tick(1'b0, 1'b0, 32'h0);
      chk($sformatf("badlen%0d_idle", k), 64'(finish), 64'h0);
    end

    // 300 read mismatches saturate the counter
    for (int i = 0; i < 300; i++) load(i, 1'b1, 8'(i), 32'h1000 + 32'(i));
    cfg_len = 10'd300;
    tick(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 300; i++) tick(1'b0, 1'b1, 32'hFFFF_0000);
    chk("mm_saturate", 64'({finish, mismatch_cnt}), 64'({1'b1, 8'd255}));
    tick(1'b0, 1'b0, 32'h0);

    // randomized episodes against the model
    for (int ep = 0; ep < 60; ep++) begin
      int hit_pct;
      int sel;
      sel = $urandom_range(0, 2);
      hit_pct = (sel == 0) ? 90 : (sel == 1) ? 50 : 5;
      sel = $urandom_range(0, 19);
      cfg_len = (sel == 0) ? 10'd0 : (sel == 1) ? 10'(DEPTH + 1 + $urandom_range(0, 3))
                                                : 10'($urandom_range(1, 12));
      for (int c = 0; c < 250; c++) begin
        logic st, h;
        logic [31:0] rd;
        st = (c == 0) ? 1'b1 : ($urandom_range(0, 3) == 0);
        h  = ($urandom_range(0, 99) < hit_pct);
        rd = ($urandom_range(0, 1) == 0 && m_idx < DEPTH) ? m_data[m_idx] : $urandom;
        if ($urandom_range(0, 4) == 0) begin
          cfg_we = 1'b1; cfg_idx = 9'($urandom_range(0, 15)); cfg_rw = 1'($urandom);
          cfg_addr = 8'($urandom); cfg_data = $urandom_range(0, 3);
        end
        tick(st, h, rd);
        if (c > 0 && m_state == M_IDLE) break;
      end
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
